// File: rtl/uart_prog_pkg.sv
// Shared types and default constants for the UART program loader.
package uart_prog_pkg;

  // Receiver frame states.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // 40 MHz clock, 115200 baud.
  localparam int          DEF_CLKS_PER_BIT = 347;
  localparam int          DEF_WORD_BYTES   = 4;
  localparam int          DEF_ADDR_W       = 10;
  localparam logic [63:0] DEF_END_WORD     = 64'h0000_0000_0000_0FFF;

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: input synchroniser, bit timing and frame FSM.
// Emits single-cycle byte_valid / frame_err strobes in the cycle of the stop-bit sample.
module uart_rx_core
  import uart_prog_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int CNT_W   = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF_M1 = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_M1);

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic [1:0]       r_settle;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_armed;

  rx_state_t        w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [2:0]       w_bit_idx_next;
  logic [7:0]       w_shift_next;
  logic             w_armed_next;
  logic             w_byte_valid;
  logic             w_frame_err;
  logic             w_settled;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Counts out the synchroniser's reset value so a line that is low after reset
  // is not mistaken for a fresh start edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_settle <= 2'd0;
    end else if (r_settle != 2'd2) begin
      r_settle <= r_settle + 2'd1;
    end
  end

  assign w_settled = (r_settle == 2'd2);

  // Frame FSM state and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_armed   <= w_armed_next;
    end
  end

  // Next-state and strobe decode. A start edge is only honoured once the line
  // has been seen high (armed), so partial frames after reset, disable or a
  // framing error are skipped.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt + CNT_W'(1);
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_armed_next   = r_armed;
    w_byte_valid   = 1'b0;
    w_frame_err    = 1'b0;
    if (!i_en) begin
      w_state_next   = RX_IDLE;
      w_cnt_next     = '0;
      w_bit_idx_next = 3'd0;
      w_armed_next   = 1'b0;
    end else begin
      case (r_state)
        RX_IDLE: begin
          w_cnt_next     = '0;
          w_bit_idx_next = 3'd0;
          if (!r_armed) begin
            if (w_settled && r_rx_sync) w_armed_next = 1'b1;
          end else if (!r_rx_sync) begin
            w_state_next = RX_START;
          end
        end
        RX_START: begin
          if (r_cnt == CNT_HALF) begin
            w_cnt_next   = '0;
            w_state_next = r_rx_sync ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (r_cnt == CNT_FULL) begin
            w_cnt_next     = '0;
            w_shift_next   = {r_rx_sync, r_shift[7:1]};
            w_bit_idx_next = r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) w_state_next = RX_STOP;
          end
        end
        RX_STOP: begin
          if (r_cnt == CNT_FULL) begin
            w_cnt_next   = '0;
            w_state_next = RX_IDLE;
            if (r_rx_sync) begin
              w_byte_valid = 1'b1;
            end else begin
              w_frame_err  = 1'b1;
              w_armed_next = 1'b0;
            end
          end
        end
        default: w_state_next = RX_IDLE;
      endcase
    end
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = w_byte_valid;
  assign o_frame_err  = w_frame_err;

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: assembles received bytes into little-endian words and
// writes them to sequential memory addresses until the terminator word arrives.
module uart_prog_loader
  import uart_prog_pkg::*;
#(
  parameter int          CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int          WORD_BYTES   = DEF_WORD_BYTES,
  parameter int          ADDR_W       = DEF_ADDR_W,
  parameter logic [63:0] END_WORD     = DEF_END_WORD
) (
  input  logic                    wb_clk_i,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    rx_i,
  output logic                    mem_we_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [8*WORD_BYTES-1:0] mem_wdata_o,
  output logic                    done_o,
  output logic                    frame_err_o,
  output logic                    ovf_o
);

  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int BCNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE  = BCNT_W'(WORD_BYTES - 1);
  localparam logic [DATA_W-1:0] END_WORD_W = END_WORD[DATA_W-1:0];
  localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;

  logic [BCNT_W-1:0] r_byte_cnt;
  logic [DATA_W-1:0] r_word;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_done;
  logic              r_frame_err;
  logic              r_ovf;

  logic              w_core_en;
  logic [7:0]        w_rx_byte;
  logic              w_rx_valid;
  logic              w_rx_frame_err;
  logic [DATA_W-1:0] w_word_next;
  logic              w_word_done;

  // Once loading is done the receiver is held idle so the line is ignored.
  assign w_core_en = en_i & ~r_done;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clk        (wb_clk_i),
    .i_rst_n      (rst_n),
    .i_en         (w_core_en),
    .i_rx         (rx_i),
    .o_byte       (w_rx_byte),
    .o_byte_valid (w_rx_valid),
    .o_frame_err  (w_rx_frame_err)
  );

  // Drop the incoming byte into its lane; the first byte lands in bits [7:0].
  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
    assign w_word_next[gi*8 +: 8] = (r_byte_cnt == BCNT_W'(gi)) ? w_rx_byte
                                                                 : r_word[gi*8 +: 8];
  end

  assign w_word_done = w_rx_valid && (r_byte_cnt == LAST_BYTE);

  // Byte counter and partial word; disable discards the partial word.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= '0;
      r_word     <= '0;
    end else if (!en_i) begin
      r_byte_cnt <= '0;
      r_word     <= '0;
    end else if (w_rx_valid) begin
      if (w_word_done) begin
        r_byte_cnt <= '0;
        r_word     <= '0;
      end else begin
        r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
        r_word     <= w_word_next;
      end
    end
  end

  // Memory write port, address pointer and sticky status flags. The output
  // address/data registers only load on a write so they hold between strobes.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wr_addr   <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_rx_frame_err) r_frame_err <= 1'b1;
      if (w_word_done) begin
        if (w_word_next == END_WORD_W) begin
          r_done <= 1'b1;
        end else if (!r_ovf) begin
          r_we        <= 1'b1;
          r_mem_addr  <= r_wr_addr;
          r_mem_wdata <= w_word_next;
          if (r_wr_addr == ADDR_MAX) begin
            r_ovf <= 1'b1;
          end else begin
            r_wr_addr <= r_wr_addr + ADDR_W'(1);
          end
        end
      end
    end
  end

  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign done_o      = r_done;
  assign frame_err_o = r_frame_err;
  assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: stimulus pushes expected writes,
// a negedge monitor pops and checks every mem_we_o strobe.
module tb_uart_prog_loader;

  localparam int CPB = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        rx;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        done;
  logic        frame_err;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .WORD_BYTES  (4),
    .ADDR_W      (4),
    .END_WORD    (64'h0000_0FFF)
  ) dut (
    .wb_clk_i    (clk),
    .rst_n       (rst_n),
    .en_i        (en),
    .rx_i        (rx),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .done_o      (done),
    .frame_err_o (frame_err),
    .ovf_o       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got still running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " we"},        64'(mem_we),    64'd0);
    chk({tag, " addr"},      64'(mem_addr),  64'd0);
    chk({tag, " wdata"},     64'(mem_wdata), 64'd0);
    chk({tag, " done"},      64'(done),      64'd0);
    chk({tag, " frame_err"}, 64'(frame_err), 64'd0);
    chk({tag, " ovf"},       64'(ovf),       64'd0);
  endtask

  task automatic expect_write(input logic [3:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    q.push_back(e);
  endtask

  // One UART frame: start, 8 data bits LSB first, stop, then idle high.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected write: got addr %0h data %0h, required no write",
                 mem_addr, mem_wdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("write addr", 64'(mem_addr),  64'(e.addr));
        chk("write data", 64'(mem_wdata), 64'(e.data));
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    en    = 1'b1;
    rx    = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Single word assembled little-endian.
    expect_write(4'd0, 32'h1234_5678);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    repeat (20) @(negedge clk);
    chk("word1 pending", 64'(q.size()), 64'd0);
    chk("hold addr", 64'(mem_addr), 64'd0);
    chk("hold wdata", 64'(mem_wdata), 64'h1234_5678);

    // One-cycle glitch: no byte, no error, receiver still usable.
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch frame_err", 64'(frame_err), 64'd0);
    expect_write(4'd1, 32'h0A0B_0C0D);
    send_word(32'h0A0B_0C0D);
    chk("after glitch pending", 64'(q.size()), 64'd0);

    // Bad stop bit: byte dropped, flag set, word counting unaffected.
    send_byte(8'hEF, 1'b0);
    chk("frame_err set", 64'(frame_err), 64'd1);
    expect_write(4'd2, 32'h1122_3344);
    send_word(32'h1122_3344);
    expect_write(4'd3, 32'h5566_7788);
    send_byte(8'h88, 1'b1);
    send_byte(8'h77, 1'b1);
    send_byte(8'h99, 1'b0);
    send_byte(8'h66, 1'b1);
    send_byte(8'h55, 1'b1);
    chk("frame err words pending", 64'(q.size()), 64'd0);

    // Disable mid-word discards the partial word but keeps address and flags.
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    en = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    repeat (5) @(negedge clk);
    expect_write(4'd4, 32'hCAFE_BABE);
    send_word(32'hCAFE_BABE);
    chk("en word pending", 64'(q.size()), 64'd0);
    chk("frame_err sticky", 64'(frame_err), 64'd1);

    // Terminator: done set, no write, further traffic ignored.
    expect_write(4'd5, 32'hAAAA_0001);
    send_word(32'hAAAA_0001);
    chk("done before end", 64'(done), 64'd0);
    send_word(32'h0000_0FFF);
    chk("done set", 64'(done), 64'd1);
    chk("end pending", 64'(q.size()), 64'd0);
    send_word(32'h0102_0304);
    chk("done sticky", 64'(done), 64'd1);
    chk("after done addr", 64'(mem_addr), 64'd5);
    chk("after done wdata", 64'(mem_wdata), 64'hAAAA_0001);

    // Fresh reset.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset2");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Address overflow: 16 writes, then the 17th word is dropped.
    for (int i = 0; i < 17; i++) begin
      if (i < 16) expect_write(4'(i), 32'h1000_0000 | 32'(i));
      send_word(32'h1000_0000 | 32'(i));
      if (i == 14) chk("ovf before last", 64'(ovf), 64'd0);
      if (i == 15) chk("ovf after 16th", 64'(ovf), 64'd1);
    end
    chk("ovf pending", 64'(q.size()), 64'd0);
    chk("ovf addr held", 64'(mem_addr), 64'd15);
    chk("ovf wdata held", 64'(mem_wdata), 64'h1000_000F);

    // Reset during the data bits of the second byte of a word.
    send_byte(8'h5A, 1'b1);
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("async reset");
        repeat (3) @(negedge clk);
        chk_zero("mid-byte reset");
        rst_n = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    expect_write(4'd0, 32'hDEAD_BEEF);
    send_word(32'hDEAD_BEEF);
    repeat (10) @(negedge clk);
    chk("post reset pending", 64'(q.size()), 64'd0);
    chk("post reset ovf", 64'(ovf), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
